mux_sincrono_param: RTL

- Parametrised successor to the team's registered 4:1 bit selector.
- Selects one of CHANNELS input words of DATA_W bits and registers it on iClock.
- Selection is either fixed by iSelector or by round-robin scan over the channels whose iValid is set.
- The output register has a valid/ready handshake and a per-channel acknowledge, so the block sits between several producers and one consumer in the synchronous datapath examples.

---
 rtl/mux_sincrono_pkg.sv | 9 +
 rtl/mux_sincrono_param_arbitro_rr.sv | 46 ++++
 rtl/mux_sincrono_param.sv | 69 ++++++
 3 files changed

// File: rtl/mux_sincrono_pkg.sv
// mux_sincrono_pkg: mode encodings and channel index wrap shared by the selector and its arbiter.
package mux_sincrono_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    function automatic int unsigned wrap_inc(input int unsigned k, input int unsigned n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction
endpackage

// File: rtl/mux_sincrono_param_arbitro_rr.sv
// arbitro_rr: picks the channel to capture, either the fixed selector or a round-robin scan after rLast.
module arbitro_rr
    import mux_sincrono_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] iValid,
    input  logic [SEL_W-1:0]    rLast,
    input  logic                iMode,
    input  logic [SEL_W-1:0]    iSelector,
    output logic                oGrant,
    output logic [SEL_W-1:0]    oIndex
);
    localparam int SEL_N = 1 << SEL_W;

    logic [SEL_N-1:0] valid_ext;
    logic             scan_gnt;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] cand;
    int unsigned      k;

    assign valid_ext = SEL_N'(iValid);

    // Walk last+1 .. last (wrapping modulo CHANNELS); the first valid channel wins.
    always_comb begin
        scan_gnt = 1'b0;
        scan_idx = '0;
        cand     = '0;
        k        = int'(rLast);
        for (int i = 0; i < CHANNELS; i++) begin
            k    = wrap_inc(k, CHANNELS);
            cand = SEL_W'(k);
            if (!scan_gnt && valid_ext[cand]) begin
                scan_gnt = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        oGrant = (iMode == MODE_SCAN) ? scan_gnt
                                      : (int'(iSelector) < CHANNELS) && valid_ext[iSelector];
        oIndex = (iMode == MODE_SCAN) ? scan_idx : iSelector;
    end
endmodule

// File: rtl/mux_sincrono_param.sv
// mux_sincrono_param: registered CHANNELS:1 word selector with valid/ready output and per-channel ack.
module mux_sincrono_param #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic [CHANNELS*DATA_W-1:0] iData,
    input  logic [CHANNELS-1:0]        iValid,
    input  logic [SEL_W-1:0]           iSelector,
    input  logic                       iMode,
    input  logic                       iReady,
    output logic [DATA_W-1:0]          oData,
    output logic                       oValid,
    output logic [SEL_W-1:0]           oChannel,
    output logic [CHANNELS-1:0]        oAck
);
    logic                grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                cap_en;
    logic                take;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [SEL_W-1:0]    chan_q, chan_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [CHANNELS-1:0] ack_q, ack_d;

    arbitro_rr #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
        .iValid    (iValid),
        .rLast     (last_q),
        .iMode     (iMode),
        .iSelector (iSelector),
        .oGrant    (grant),
        .oIndex    (grant_idx)
    );

    // Capture when empty or draining; an empty capture clears oValid but keeps data/channel/pointer.
    always_comb begin
        cap_en  = !valid_q || iReady;
        take    = cap_en && grant;
        data_d  = take ? iData[grant_idx*DATA_W +: DATA_W] : data_q;
        chan_d  = take ? grant_idx : chan_q;
        last_d  = take ? grant_idx : last_q;
        valid_d = cap_en ? grant : valid_q;
        ack_d   = take ? CHANNELS'(1) << grant_idx : '0;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            last_q  <= '0;
            ack_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
        end
    end

    assign oData    = data_q;
    assign oValid   = valid_q;
    assign oChannel = chan_q;
    assign oAck     = ack_q;
endmodule
